sipo_load_ctrl: RTL

Sequencer that frames a serial bit stream on IPORT[0] into a WIDTH-bit word for Register A of the toyup core. It counts qualified serial bits, drives the shift-enable and serial-data strobes into the register, and holds the assembled word with a valid flag until the core acknowledges it. It also handles inter-bit timeout and overrun, so software never sees a partial word.

---
 rtl/sipo_load_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sipo_load_ctrl.sv
// Serial-to-parallel load sequencer for Register A: frames qualified serial bits into a word,
// holds it with a valid flag until acknowledged, and aborts stalled captures on timeout.
module sipo_load_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             ack,
  output logic             shift_en,
  output logic             sh_bit,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             timeout_err,
  output logic             overrun
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             terr_q, terr_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] data_shifted;

  always_comb begin
    if (LSB_FIRST != 0) begin
      data_shifted = {sin, data_q[WIDTH-1:1]};
    end else begin
      data_shifted = {data_q[WIDTH-2:0], sin};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    data_d  = data_q;
    valid_d = valid_q;
    terr_d  = 1'b0;
    ovr_d   = ovr_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          cnt_d   = '0;
          timer_d = '0;
          data_d  = '0;
          ovr_d   = 1'b0;
        end
      end
      StShift: begin
        if (sin_vld) begin
          data_d  = data_shifted;
          timer_d = '0;
          if (cnt_q >= CNT_W'(WIDTH - 1)) begin
            state_d = StHold;
            valid_d = 1'b1;
            cnt_d   = CNT_W'(WIDTH);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (timer_q >= TMR_W'(TIMEOUT - 1)) begin
          // Stalled stream: drop the partial word so it is never exposed.
          state_d = StIdle;
          terr_d  = 1'b1;
          data_d  = '0;
          cnt_d   = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StHold: begin
        if (sin_vld) begin
          ovr_d = 1'b1;
        end
        if (ack) begin
          state_d = StIdle;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      timer_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      terr_q  <= terr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign shift_en    = (state_q == StShift) && sin_vld;
  assign sh_bit      = sin;
  assign data        = data_q;
  assign valid       = valid_q;
  assign busy        = (state_q == StShift) || (state_q == StHold);
  assign bit_cnt     = cnt_q;
  assign timeout_err = terr_q;
  assign overrun     = ovr_q;

endmodule
